// File: rtl/p_pmem_arbiter.sv
// p_pmem_arbiter
//   Arbitrates the single physical-memory port between the I-cache and the D-cache
//   line-fill/write-back path. One whole-line transaction is outstanding at a time.
//   Address, op and write data are latched at grant and held for the whole transaction.
//   A one-cycle GAP after each completion absorbs a client still holding its request
//   for one cycle after its resp, so no duplicate transaction is issued.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   defined   - a last_served register breaks simultaneous I/D requests in favour of the
//               client not served last.
//   undefined - fixed D-over-I priority.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_pmem_read/_address        I-cache line-read request and address
//   i_pmem_rdata/_resp          line data and completion to the I-cache
//   d_pmem_read/_write/_address/_wdata  D-cache read/evict request, address and data
//   d_pmem_rdata/_resp          line data and completion to the D-cache
//   mem_read/_write/_address/_wdata     request to the cacheline adaptor
//   mem_rdata/_resp             line data and completion from the adaptor
module p_pmem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   typedef enum logic [1:0] {StIdle, StIServe, StDServe, StGap} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    op_q, op_d;      // 1 = write
   logic                    d_req;
   logic                    d_wins;

   assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q, last_d;                     // 0 = I served last, 1 = D
   // On a tie, D loses only if it was the one served last.
   assign d_wins = d_req & ~(i_pmem_read & last_q);
`else
   assign d_wins = d_req;
`endif

   // Read data is a straight pass-through; resp qualifies it.
   assign i_pmem_rdata = mem_rdata;
   assign d_pmem_rdata = mem_rdata;
   assign mem_address  = addr_q;
   assign mem_wdata    = wdata_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      op_d        = op_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (d_wins) begin
               state_d = StDServe;
               addr_d  = d_pmem_address;
               wdata_d = d_pmem_wdata;
               // Write takes precedence if a client asserts both.
               op_d    = d_pmem_write;
            end else if (i_pmem_read) begin
               state_d = StIServe;
               addr_d  = i_pmem_address;
               op_d    = 1'b0;
            end
         end
         StIServe: begin
            mem_read = 1'b1;
            if (mem_resp) begin
               // A client that dropped its request mid-burst gets no resp.
               i_pmem_resp = i_pmem_read;
               state_d     = StGap;
`ifdef ARB_ROUND_ROBIN_EN
               last_d      = 1'b0;
`endif
            end
         end
         StDServe: begin
            mem_read  = ~op_q;
            mem_write = op_q;
            if (mem_resp) begin
               d_pmem_resp = d_req;
               state_d     = StGap;
`ifdef ARB_ROUND_ROBIN_EN
               last_d      = 1'b1;
`endif
            end
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_p_pmem_arbiter.sv
module tb_p_pmem_arbiter;
   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_pmem_read = 1'b0;
   logic [AW-1:0] i_pmem_address = '0;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read = 1'b0;
   logic          d_pmem_write = 1'b0;
   logic [AW-1:0] d_pmem_address = '0;
   logic [LW-1:0] d_pmem_wdata = '0;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata = '0;
   logic          mem_resp = 1'b0;

   always #5 clk = ~clk;

   p_pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   // Reference model: who owns the memory port, what was captured at grant,
   // and whether we are in the one-cycle cooldown after a completion.
   int            m_owner = 0;   // 0 none, 1 I, 2 D
   bit            m_cool  = 1'b0;
   bit            m_op    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [LW-1:0] m_wdata = '0;
   bit            m_last  = 1'b0; // last completed owner was D
   bit            m_valid = 1'b0;

   always @(negedge clk) begin
      bit er, ew, ei, ed, dq, pick_d;
      er = (m_owner == 1) || (m_owner == 2 && !m_op);
      ew = (m_owner == 2) && m_op;
      ei = (m_owner == 1) && mem_resp && i_pmem_read;
      ed = (m_owner == 2) && mem_resp && (d_pmem_read || d_pmem_write);
      if (m_valid) begin
         chk("mem_read", LW'(mem_read), LW'(er));
         chk("mem_write", LW'(mem_write), LW'(ew));
         chk("i_pmem_resp", LW'(i_pmem_resp), LW'(ei));
         chk("d_pmem_resp", LW'(d_pmem_resp), LW'(ed));
         chk("i_pmem_rdata", i_pmem_rdata, mem_rdata);
         chk("d_pmem_rdata", d_pmem_rdata, mem_rdata);
         if (er || ew) chk("mem_address", LW'(mem_address), LW'(m_addr));
         if (ew) chk("mem_wdata", mem_wdata, m_wdata);
      end
      dq = d_pmem_read || d_pmem_write;
      if (rst) begin
         m_owner = 0; m_cool = 0; m_op = 0; m_addr = '0; m_wdata = '0; m_last = 0;
         m_valid = 1'b1;
      end else if (m_cool) begin
         m_cool = 1'b0;
      end else if (m_owner != 0) begin
         if (mem_resp) begin
            m_last  = (m_owner == 2);
            m_owner = 0;
            m_cool  = 1'b1;
         end
      end else if (dq || i_pmem_read) begin
         if (dq && i_pmem_read) pick_d = RoundRobin ? !m_last : 1'b1;
         else                   pick_d = dq;
         if (pick_d) begin
            m_owner = 2; m_op = d_pmem_write; m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
         end else begin
            m_owner = 1; m_op = 0; m_addr = i_pmem_address;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nrise;
      bit prev_rd;
      bit i_first;
      logic [AW-1:0] first_a, second_a;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst mem_read", LW'(mem_read), '0);
      chk("rst mem_write", LW'(mem_write), '0);
      chk("rst mem_address", LW'(mem_address), '0);
      chk("rst resp", LW'({i_pmem_resp, d_pmem_resp}), '0);
      step();

      // I-only read, adaptor responds on the 4th serve cycle; I holds one extra cycle.
      nrise = 0; prev_rd = 0;
      for (int c = 0; c < 8; c++) begin
         i_pmem_read    = (c <= 5);
         i_pmem_address = 32'h0000_0060;
         mem_resp       = (c == 4);
         mem_rdata      = rand_line();
         if (c == 1) begin
            chk("model owner I", LW'(m_owner), LW'(1));
            chk("model addr I", LW'(m_addr), LW'(32'h60));
         end
         @(negedge clk);
         chk("I mem_read", LW'(mem_read), LW'(c >= 1 && c <= 4));
         chk("I i_resp", LW'(i_pmem_resp), LW'(c == 4));
         if (c >= 1 && c <= 4) chk("I mem_address", LW'(mem_address), LW'(32'h60));
         if (c == 4) chk("I rdata", i_pmem_rdata, mem_rdata);
         if (mem_read && !prev_rd) nrise++;
         prev_rd = mem_read;
         step();
      end
      chk("I transactions", LW'(nrise), LW'(1));

      // D write with address change mid-serve.
      nrise = 0;
      for (int c = 0; c < 6; c++) begin
         d_pmem_write   = (c <= 3);
         d_pmem_address = (c >= 2) ? 32'h0000_0040 : 32'h8000_0100;
         d_pmem_wdata   = (c == 0) ? {32{8'hA5}} : rand_line();
         mem_resp       = (c == 3);
         @(negedge clk);
         chk("Dw mem_write", LW'(mem_write), LW'(c >= 1 && c <= 3));
         chk("Dw mem_read", LW'(mem_read), '0);
         chk("Dw d_resp", LW'(d_pmem_resp), LW'(c == 3));
         if (c >= 1 && c <= 3) begin
            chk("Dw mem_address", LW'(mem_address), LW'(32'h8000_0100));
            chk("Dw mem_wdata", mem_wdata, {32{8'hA5}});
         end
         if (d_pmem_resp) nrise++;
         step();
      end
      chk("Dw resp pulses", LW'(nrise), LW'(1));

      // Simultaneous requests; D was served last.
      i_first  = RoundRobin;
      first_a  = i_first ? 32'h200 : 32'h300;
      second_a = i_first ? 32'h300 : 32'h200;
      i_pmem_address = 32'h200;
      d_pmem_address = 32'h300;
      for (int c = 0; c < 9; c++) begin
         i_pmem_read = i_first ? (c <= 3) : (c <= 6);
         d_pmem_read = i_first ? (c <= 6) : (c <= 3);
         mem_resp    = (c == 2 || c == 5);
         @(negedge clk);
         chk("Sim mem_read", LW'(mem_read), LW'(c == 1 || c == 2 || c == 5));
         if (c == 1 || c == 2) chk("Sim first addr", LW'(mem_address), LW'(first_a));
         if (c == 5) chk("Sim second addr", LW'(mem_address), LW'(second_a));
         chk("Sim i_resp", LW'(i_pmem_resp), LW'(i_first ? c == 2 : c == 5));
         chk("Sim d_resp", LW'(d_pmem_resp), LW'(i_first ? c == 5 : c == 2));
         step();
      end

      // Reset while I is being served.
      for (int c = 0; c < 6; c++) begin
         i_pmem_read    = (c <= 1);
         i_pmem_address = 32'h400;
         rst            = (c == 2);
         mem_resp       = 1'b0;
         @(negedge clk);
         chk("Rst mem_read", LW'(mem_read), LW'(c == 1 || c == 2));
         chk("Rst resp", LW'({i_pmem_resp, d_pmem_resp}), '0);
         step();
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 299) == 0);
         mem_rdata = rand_line();
         mem_resp  = (mem_read || mem_write) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 7) == 0);
         if (!i_pmem_read) begin
            if ($urandom_range(0, 2) == 0) begin
               i_pmem_read = 1'b1; i_pmem_address = $urandom;
            end
         end else if ($urandom_range(0, 5) == 0) i_pmem_read = 1'b0;
         else if ($urandom_range(0, 9) == 0) i_pmem_address = $urandom;
         if (!(d_pmem_read || d_pmem_write)) begin
            if ($urandom_range(0, 2) == 0) begin
               int k;
               k = $urandom_range(0, 9);
               d_pmem_read    = (k < 5) || (k == 9);
               d_pmem_write   = (k >= 5);
               d_pmem_address = $urandom;
               d_pmem_wdata   = rand_line();
            end
         end else if ($urandom_range(0, 5) == 0) begin
            d_pmem_read = 1'b0; d_pmem_write = 1'b0;
         end else if ($urandom_range(0, 9) == 0) begin
            d_pmem_address = $urandom;
            d_pmem_wdata   = rand_line();
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/p_pmem_arbiter.md
Name: p_pmem_arbiter

Overview:
- Arbitrates the single physical-memory port between the pipelined I-cache and the D-cache line-fill/write-back path.
- Sits directly downstream of the I-cache controller: it consumes the I-cache's pmem_read/address and returns pmem_resp and the line data.
- Feeds the cacheline adaptor. Only one whole-line transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, physical byte-address width.
- LINE_WIDTH, 256, cache-line width in bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- i_pmem_read  input  1  I-cache line-read request, held until i_pmem_resp
- i_pmem_address  input  ADDR_WIDTH  I-cache line address
- i_pmem_rdata  output  LINE_WIDTH  line data to I-cache
- i_pmem_resp  output  1  I-cache transaction complete
- d_pmem_read  input  1  D-cache line-read request
- d_pmem_write  input  1  D-cache line-write (eviction) request
- d_pmem_address  input  ADDR_WIDTH  D-cache line address
- d_pmem_wdata  input  LINE_WIDTH  D-cache eviction data
- d_pmem_rdata  output  LINE_WIDTH  line data to D-cache
- d_pmem_resp  output  1  D-cache transaction complete
- mem_read  output  1  read request to adaptor
- mem_write  output  1  write request to adaptor
- mem_address  output  ADDR_WIDTH  latched line address
- mem_wdata  output  LINE_WIDTH  latched write data
- mem_rdata  input  LINE_WIDTH  line returned by adaptor
- mem_resp  input  1  adaptor transaction complete

Behaviour:
- States: IDLE, I_SERVE, D_SERVE, GAP.
- Reset values: state=IDLE. mem_read, mem_write, i_pmem_resp and d_pmem_resp are 0. Latched address, write data and op register are 0. rdata outputs carry mem_rdata unconditionally.
- IDLE, grant selection:
  - Only I requesting -> I_SERVE.
  - Only D requesting -> D_SERVE.
  - Both requesting -> D_SERVE (fixed priority).
- IDLE, latching on grant: address, op, and wdata (D only) are latched from the winning client. d_pmem_write=1 latches op=write, even if d_pmem_read is also 1; that combination is illegal but defined.
- Latency: a request seen in IDLE at cycle N puts mem_read/mem_write high from cycle N+1.
- I_SERVE: mem_read=1; mem_address comes from the latch.
- D_SERVE: mem_read=~op and mem_write=op; mem_address and mem_wdata come from the latch. Latched values are constant for the whole transaction, even if the client inputs change.
- Completion: mem_resp in a SERVE state drives the granted client's resp=1 combinationally in that same cycle, then state goes to GAP. The non-granted client's resp is never asserted.
- Client drop mid-transaction: the arbiter still holds the memory request until mem_resp (bursts cannot abort). That mem_resp is not forwarded to the client; state goes to GAP.
- GAP: exactly one cycle. No memory request, no resp, returns to IDLE. This absorbs the I-cache holding pmem_read one cycle past its resp, so no duplicate fetch is issued.
- mem_resp outside a SERVE state is ignored.
- rst mid-transaction: state returns to IDLE and all requests drop the next cycle. The adaptor is reset on the same rst.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_served register (reset 0 = I) is updated on each completed grant. On a simultaneous I/D request in IDLE, the client not last served wins.
- Undefined: fixed D-over-I priority; no last_served register.
- All other behaviour is identical.

Test Plan:
- I-only: i_pmem_read=1, addr 0x0000_0060; mem_resp after 4 cycles -> mem_read high cycles 1-4, mem_address=0x60, i_pmem_resp=1 on cycle 4 with i_pmem_rdata=mem_rdata, then GAP then IDLE.
- D write: d_pmem_write=1, addr 0x8000_0100, wdata=all 0xA5 -> mem_write=1, mem_read=0, mem_wdata latched; d_pmem_resp pulses once.
- Simultaneous: both request at cycle 0 -> D served first (macro off), I granted the cycle after GAP. With the macro on and last_served=D -> I served first.
- Guard: i_pmem_read held one cycle after i_pmem_resp -> no new mem_read in GAP, exactly one transaction counted.
- Address change mid-serve: d_pmem_address changes to 0x40 during D_SERVE -> mem_address stays at the original value.
- Reset: rst=1 for one cycle while in I_SERVE -> mem_read=0 the next cycle, state IDLE, no resp pulses.
